// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo
//   Elastic pipeline-stage buffer: DEPTH-entry valid/ready FIFO carrying an
//   opaque WIDTH-bit payload between two pipeline stages. It supports
//   back-pressure, a synchronous flush and an occupancy count.
//
//   Optional feature macro: PIPE_FWD_EN
//     When defined, the module exposes the youngest valid entry on
//     fwd_data/fwd_enable so decode can forward in-flight results.
//     When it is not defined, those ports and their logic are absent.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset (0 = reset)
//   flush      drop all entries on the next edge
//   in_valid   producer presents in_data
//   in_ready   buffer can accept this cycle (registered state only)
//   in_data    payload from the upstream stage
//   out_valid  out_data holds the oldest entry
//   out_ready  consumer takes out_data this cycle
//   out_data   oldest entry
//   count      current occupancy, 0..DEPTH
//   fwd_enable youngest entry valid         (PIPE_FWD_EN only)
//   fwd_data   youngest entry, 0 when empty (PIPE_FWD_EN only)
module pipe_stage_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
`ifdef PIPE_FWD_EN
    ,
    output logic             fwd_enable,
    output logic [WIDTH-1:0] fwd_data
`endif
);

    // Pointer width: at least one bit, so that DEPTH == 1 still works.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] storage;
    logic [PW-1:0]               rd_ptr;
    logic [PW-1:0]               wr_ptr;
    logic                        push;
    logic                        pop;

    // Handshake flags come only from registered count. A full buffer
    // therefore never accepts data in the same cycle as a pop.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = storage[rd_ptr];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Wrap the pointer explicitly, because DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            storage <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else if (flush) begin
            // Storage keeps its contents. Only the bookkeeping is cleared.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                storage[wr_ptr] <= in_data;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef PIPE_FWD_EN
    // The youngest entry sits one slot behind wr_ptr. The output is gated
    // with occupancy, so it reads 0 after a flush even though storage
    // still holds the old data.
    logic [PW-1:0] yng_ptr;
    assign yng_ptr    = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - 1'b1;
    assign fwd_enable = (count != '0);
    assign fwd_data   = fwd_enable ? storage[yng_ptr] : '0;
`endif

    a_count_le_depth : assert property (@(posedge clk) disable iff (!reset)
        count <= CW'(DEPTH));
    a_no_push_full : assert property (@(posedge clk) disable iff (!reset)
        (count == CW'(DEPTH)) |-> !push);

endmodule
